// File: rtl/cpu_axil_bridge_pkg.sv
// cpu_axil_pkg: shared types and constants for the CPU data-port to AXI4-lite bridge.
//   bridge_state_t      - bridge FSM encoding
//   RESP_*              - AXI response codes
//   ADDR_LO/HI_DEFAULT  - default accepted window for the optional range check
package cpu_axil_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,   // AW and W outstanding, completed independently
        WRESP = 3'd2,
        RADDR = 3'd3,
        RRESP = 3'd4,
        ERR   = 3'd5    // out-of-range request, answered locally
    } bridge_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] ADDR_LO_DEFAULT = 32'h0000_8000;  // inclusive
    localparam logic [31:0] ADDR_HI_DEFAULT = 32'h0000_8138;  // exclusive

endpackage

// File: rtl/cpu_axil_bridge_if.sv
// Bus interfaces used by cpu_axil_bridge.
//   cpu_data_if : core data-memory port. The core is master, the bridge is slave.
//                 data_req/we/be/addr/wdata (request), data_gnt (accept),
//                 data_rvalid/rdata/err (response pulse).
//   axil_if     : AXI4-lite bus. The bridge is master, the peripheral is slave.
//                 AW/W/B/AR/R channels with valid/ready handshakes.
interface cpu_data_if #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int SW = 4
);
    logic          data_req;
    logic          data_we;
    logic [SW-1:0] data_be;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_gnt;
    logic          data_rvalid;
    logic [DW-1:0] data_rdata;
    logic          data_err;

    modport master (
        output data_req, data_we, data_be, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata, data_err
    );

    modport slave (
        input  data_req, data_we, data_be, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata, data_err
    );
endinterface

interface axil_if #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int SW = 4
);
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/cpu_axil_bridge.sv
// cpu_axil_bridge: single-outstanding bridge from the core data port to AXI4-lite.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   cpu           : cpu_data_if.slave  - request accepted combinationally in IDLE,
//                                        response as a one-cycle data_rvalid pulse
//   axi           : axil_if.master     - registered valids, AW and W issued together
// Configuration:
//   CPU_AXIL_BRIDGE_RANGE_CHECK_EN - when defined, requests outside
//   [ADDR_LO, ADDR_HI) are answered locally with data_err=1 and no AXI traffic.
module cpu_axil_bridge
    import cpu_axil_pkg::*;
#(
    parameter int            DW      = 32,
    parameter int            AW      = 32,
    parameter int            SW      = 4,
    parameter logic [AW-1:0] ADDR_LO = AW'(ADDR_LO_DEFAULT),
    parameter logic [AW-1:0] ADDR_HI = AW'(ADDR_HI_DEFAULT)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    cpu_data_if.slave  cpu,
    axil_if.master     axi
);

    // Elaboration-time sanity checks on the configuration.
    if (SW * 8 != DW) begin : g_bad_sw
        $error("cpu_axil_bridge: SW must equal DW/8");
    end
    if (ADDR_HI <= ADDR_LO) begin : g_bad_range
        $error("cpu_axil_bridge: ADDR_HI must be above ADDR_LO");
    end

    bridge_state_t state_q, state_d;

    logic [AW-1:0] addr_q,  addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] be_q,    be_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q,  w_done_d;

    logic          awvalid_q, awvalid_d;
    logic          wvalid_q,  wvalid_d;
    logic          bready_q,  bready_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q,  rready_d;

    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q,   rsp_err_d;

    logic gnt;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Gated by reset so a request seen while the flops are held is never granted.
    assign gnt   = cpu.data_req && (state_q == IDLE) && rst_ni;

    // Handshakes only count in the state that owns the channel; AXI inputs
    // are ignored everywhere else.
    assign aw_hs = (state_q == WADDR) && awvalid_q && axi.awready;
    assign w_hs  = (state_q == WADDR) && wvalid_q  && axi.wready;
    assign b_hs  = (state_q == WRESP) && bready_q  && axi.bvalid;
    assign ar_hs = (state_q == RADDR) && arvalid_q && axi.arready;
    assign r_hs  = (state_q == RRESP) && rready_q  && axi.rvalid;

`ifdef CPU_AXIL_BRIDGE_RANGE_CHECK_EN
    logic addr_ok;
    assign addr_ok = (cpu.data_addr >= ADDR_LO) && (cpu.data_addr < ADDR_HI);
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = 1'b0;          // response is a single-cycle pulse
        rsp_rdata_d = rsp_rdata_q;   // rdata/err hold after the pulse
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (gnt) begin
                    // The write flag is carried by the next state, so it is
                    // not kept as a separate register.
                    addr_d  = cpu.data_addr;
                    wdata_d = cpu.data_wdata;
                    be_d    = cpu.data_be;
`ifdef CPU_AXIL_BRIDGE_RANGE_CHECK_EN
                    if (!addr_ok) begin
                        state_d     = ERR;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else
`endif
                    if (cpu.data_we) begin
                        state_d   = WADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end

            WADDR: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Either channel may finish first, or both in the same cycle.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d   = WRESP;
                    bready_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end

            WRESP: begin
                if (b_hs) begin
                    state_d     = IDLE;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (axi.bresp != RESP_OKAY);
                    rsp_rdata_d = '0;
                end
            end

            RADDR: begin
                if (ar_hs) begin
                    state_d   = RRESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end

            RRESP: begin
                if (r_hs) begin
                    state_d     = IDLE;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (axi.rresp != RESP_OKAY);
                    rsp_rdata_d = axi.rdata;
                end
            end

            // ERR only lasts for the locally generated response cycle.
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cpu.data_gnt    = gnt;
    assign cpu.data_rvalid = rsp_valid_q;
    assign cpu.data_rdata  = rsp_rdata_q;
    assign cpu.data_err    = rsp_err_q;

    assign axi.awaddr  = addr_q;
    assign axi.araddr  = addr_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = be_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

endmodule

// File: tb/tb_cpu_axil_bridge.sv
// Directed self-checking bench for cpu_axil_bridge.
// Inputs are driven 1 time unit after the rising edge, outputs checked 1 unit later.
module tb_cpu_axil_bridge;
    import cpu_axil_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    cpu_data_if #(.DW(32), .AW(32), .SW(4)) cpu_if ();
    axil_if     #(.DW(32), .AW(32), .SW(4)) axi_if ();

    cpu_axil_bridge #(.DW(32), .AW(32), .SW(4)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .cpu    (cpu_if.slave),
        .axi    (axi_if.master)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int rv_cnt = 0;

    // Count response pulses away from the active edge.
    always @(negedge clk_i) if (cpu_if.data_rvalid === 1'b1) rv_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic all_zero(input string p);
        check({p, "_gnt"},     32'(cpu_if.data_gnt),    32'h0);
        check({p, "_rvalid"},  32'(cpu_if.data_rvalid), 32'h0);
        check({p, "_err"},     32'(cpu_if.data_err),    32'h0);
        check({p, "_rdata"},   cpu_if.data_rdata,       32'h0);
        check({p, "_awvalid"}, 32'(axi_if.awvalid),     32'h0);
        check({p, "_wvalid"},  32'(axi_if.wvalid),      32'h0);
        check({p, "_arvalid"}, 32'(axi_if.arvalid),     32'h0);
        check({p, "_bready"},  32'(axi_if.bready),      32'h0);
        check({p, "_rready"},  32'(axi_if.rready),      32'h0);
        check({p, "_awaddr"},  axi_if.awaddr,           32'h0);
        check({p, "_araddr"},  axi_if.araddr,           32'h0);
        check({p, "_wdata"},   axi_if.wdata,            32'h0);
        check({p, "_wstrb"},   32'(axi_if.wstrb),       32'h0);
    endtask

    task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        cpu_if.data_req   = 1'b1;
        cpu_if.data_we    = we;
        cpu_if.data_addr  = a;
        cpu_if.data_wdata = d;
        cpu_if.data_be    = be;
    endtask

    int rv0;

    initial begin
        cpu_if.data_req = 0; cpu_if.data_we = 0; cpu_if.data_be = 0;
        cpu_if.data_addr = 0; cpu_if.data_wdata = 0;
        axi_if.awready = 0; axi_if.wready = 0; axi_if.bvalid = 0; axi_if.bresp = 0;
        axi_if.arready = 0; axi_if.rvalid = 0; axi_if.rresp = 0; axi_if.rdata = 0;

        // Reset state
        #2;
        all_zero("rst");
        tick(); tick();
        rst_ni = 1'b1;
        tick();

        // Write 8010, all ready in cycle 1, bvalid in cycle 2
        req(1'b1, 32'h8010, 32'hA5A5_1234, 4'hF); #1;
        check("w1_gnt", 32'(cpu_if.data_gnt), 32'h1);
        tick(); cpu_if.data_req = 0; #1;
        check("w1_awvalid", 32'(axi_if.awvalid), 32'h1);
        check("w1_wvalid",  32'(axi_if.wvalid),  32'h1);
        check("w1_awaddr",  axi_if.awaddr,       32'h8010);
        check("w1_wdata",   axi_if.wdata,        32'hA5A5_1234);
        check("w1_wstrb",   32'(axi_if.wstrb),   32'hF);
        check("w1_bready0", 32'(axi_if.bready),  32'h0);
        axi_if.awready = 1; axi_if.wready = 1;
        tick(); axi_if.awready = 0; axi_if.wready = 0; #1;
        check("w1_awvalid_off", 32'(axi_if.awvalid), 32'h0);
        check("w1_wvalid_off",  32'(axi_if.wvalid),  32'h0);
        check("w1_bready",      32'(axi_if.bready),  32'h1);
        check("w1_rv_early",    32'(cpu_if.data_rvalid), 32'h0);
        axi_if.bvalid = 1; axi_if.bresp = RESP_OKAY;
        tick(); axi_if.bvalid = 0; #1;
        check("w1_rvalid", 32'(cpu_if.data_rvalid), 32'h1);
        check("w1_err",    32'(cpu_if.data_err),    32'h0);
        check("w1_rdata",  cpu_if.data_rdata,       32'h0);
        check("w1_bready_off", 32'(axi_if.bready),  32'h0);
        tick(); #1;
        check("w1_rvalid_pulse", 32'(cpu_if.data_rvalid), 32'h0);

        // Write with wready three cycles ahead of awready
        rv0 = rv_cnt;
        req(1'b1, 32'h8020, 32'h0BAD_F00D, 4'h3); #1;
        check("w2_gnt", 32'(cpu_if.data_gnt), 32'h1);
        tick(); cpu_if.data_req = 0; #1;
        axi_if.wready = 1;
        tick(); axi_if.wready = 0; #1;
        check("w2_wvalid_off", 32'(axi_if.wvalid),  32'h0);
        check("w2_awvalid_c2", 32'(axi_if.awvalid), 32'h1);
        check("w2_bready_c2",  32'(axi_if.bready),  32'h0);
        tick(); #1;
        check("w2_awvalid_c3", 32'(axi_if.awvalid), 32'h1);
        check("w2_bready_c3",  32'(axi_if.bready),  32'h0);
        tick(); #1;
        check("w2_awvalid_c4", 32'(axi_if.awvalid), 32'h1);
        check("w2_wstrb",      32'(axi_if.wstrb),   32'h3);
        axi_if.awready = 1;
        tick(); axi_if.awready = 0; #1;
        check("w2_awvalid_off", 32'(axi_if.awvalid), 32'h0);
        check("w2_bready",      32'(axi_if.bready),  32'h1);
        axi_if.bvalid = 1; axi_if.bresp = RESP_OKAY;
        tick(); axi_if.bvalid = 0; #1;
        check("w2_rvalid", 32'(cpu_if.data_rvalid), 32'h1);
        tick(); tick(); #1;
        check("w2_one_rvalid", 32'(rv_cnt - rv0), 32'h1);

        // Read 8074, arready in cycle 1, rvalid two cycles later
        req(1'b0, 32'h8074, 32'h0, 4'hF); #1;
        check("r1_gnt", 32'(cpu_if.data_gnt), 32'h1);
        tick(); cpu_if.data_req = 0; #1;
        check("r1_arvalid", 32'(axi_if.arvalid), 32'h1);
        check("r1_araddr",  axi_if.araddr,       32'h8074);
        check("r1_awvalid", 32'(axi_if.awvalid), 32'h0);
        axi_if.arready = 1;
        axi_if.rvalid = 0; axi_if.rdata = 32'hFFFF_FFFF;  // ignored: no rvalid
        tick(); axi_if.arready = 0; #1;
        check("r1_arvalid_off", 32'(axi_if.arvalid), 32'h0);
        check("r1_rready",      32'(axi_if.rready),  32'h1);
        tick(); #1;
        axi_if.rvalid = 1; axi_if.rdata = 32'h0000_00C3; axi_if.rresp = RESP_OKAY;
        tick(); axi_if.rvalid = 0; axi_if.rdata = 32'h1111_1111; #1;
        check("r1_rvalid", 32'(cpu_if.data_rvalid), 32'h1);
        check("r1_rdata",  cpu_if.data_rdata,       32'hC3);
        check("r1_err",    32'(cpu_if.data_err),    32'h0);
        check("r1_rready_off", 32'(axi_if.rready),  32'h0);
        tick(); #1;
        check("r1_rdata_hold", cpu_if.data_rdata,       32'hC3);
        check("r1_rvalid_off", 32'(cpu_if.data_rvalid), 32'h0);

        // Read answered with SLVERR
        req(1'b0, 32'h8100, 32'h0, 4'hF); #1;
        tick(); cpu_if.data_req = 0; #1;
        axi_if.arready = 1;
        tick(); axi_if.arready = 0; #1;
        axi_if.rvalid = 1; axi_if.rdata = 32'hDEAD_BEEF; axi_if.rresp = RESP_SLVERR;
        tick(); axi_if.rvalid = 0; axi_if.rresp = RESP_OKAY; #1;
        check("r2_rvalid", 32'(cpu_if.data_rvalid), 32'h1);
        check("r2_err",    32'(cpu_if.data_err),    32'h1);
        check("r2_rdata",  cpu_if.data_rdata,       32'hDEAD_BEEF);

        // Back-to-back: second request held high through the first
        tick();
        req(1'b0, 32'h8040, 32'h0, 4'hF); #1;
        check("bb_gnt1", 32'(cpu_if.data_gnt), 32'h1);
        tick(); req(1'b1, 32'h8030, 32'h1234_5678, 4'hC); #1;
        check("bb_gnt_busy1", 32'(cpu_if.data_gnt), 32'h0);
        axi_if.arready = 1;
        tick(); axi_if.arready = 0; #1;
        check("bb_gnt_busy2", 32'(cpu_if.data_gnt), 32'h0);
        axi_if.rvalid = 1; axi_if.rdata = 32'h0000_0011; axi_if.rresp = RESP_OKAY;
        tick(); axi_if.rvalid = 0; #1;
        check("bb_rvalid1", 32'(cpu_if.data_rvalid), 32'h1);
        check("bb_rdata1",  cpu_if.data_rdata,       32'h11);
        check("bb_gnt2",    32'(cpu_if.data_gnt),    32'h1);
        tick(); cpu_if.data_req = 0; #1;
        check("bb_awvalid", 32'(axi_if.awvalid), 32'h1);
        check("bb_awaddr",  axi_if.awaddr,       32'h8030);
        check("bb_wdata",   axi_if.wdata,        32'h1234_5678);
        check("bb_wstrb",   32'(axi_if.wstrb),   32'hC);
        axi_if.awready = 1; axi_if.wready = 1;
        tick(); axi_if.awready = 0; axi_if.wready = 0; #1;
        axi_if.bvalid = 1; axi_if.bresp = RESP_DECERR;
        tick(); axi_if.bvalid = 0; axi_if.bresp = RESP_OKAY; #1;
        check("bb_rvalid2", 32'(cpu_if.data_rvalid), 32'h1);
        check("bb_err2",    32'(cpu_if.data_err),    32'h1);
        check("bb_rdata2",  cpu_if.data_rdata,       32'h0);

`ifdef CPU_AXIL_BRIDGE_RANGE_CHECK_EN
        // Out-of-range read answered locally
        tick();
        req(1'b0, 32'h0000_1000, 32'h0, 4'hF); #1;
        check("oor_gnt", 32'(cpu_if.data_gnt), 32'h1);
        tick(); cpu_if.data_req = 0; #1;
        check("oor_rvalid",  32'(cpu_if.data_rvalid), 32'h1);
        check("oor_err",     32'(cpu_if.data_err),    32'h1);
        check("oor_rdata",   cpu_if.data_rdata,       32'h0);
        check("oor_arvalid", 32'(axi_if.arvalid),     32'h0);
        tick(); #1;
        check("oor_arvalid2", 32'(axi_if.arvalid),    32'h0);
        check("oor_rvalid2",  32'(cpu_if.data_rvalid), 32'h0);
`endif

        // Reset during WRESP
        tick();
        rv0 = rv_cnt;
        req(1'b1, 32'h8014, 32'hCAFE_0001, 4'hF); #1;
        tick(); cpu_if.data_req = 0; #1;
        axi_if.awready = 1; axi_if.wready = 1;
        tick(); axi_if.awready = 0; axi_if.wready = 0; #1;
        check("mr_bready", 32'(axi_if.bready), 32'h1);
        rst_ni = 1'b0; #1;
        all_zero("mr");
        tick(); tick();
        rst_ni = 1'b1;
        tick(); #1;
        check("mr_no_rsp", 32'(rv_cnt - rv0), 32'h0);
        req(1'b0, 32'h8008, 32'h0, 4'hF); #1;
        check("mr_gnt", 32'(cpu_if.data_gnt), 32'h1);
        tick(); cpu_if.data_req = 0; #1;
        axi_if.arready = 1;
        tick(); axi_if.arready = 0; #1;
        axi_if.rvalid = 1; axi_if.rdata = 32'h0000_005A; axi_if.rresp = RESP_OKAY;
        tick(); axi_if.rvalid = 0; #1;
        check("mr_rvalid", 32'(cpu_if.data_rvalid), 32'h1);
        check("mr_rdata",  cpu_if.data_rdata,       32'h5A);
        check("mr_err",    32'(cpu_if.data_err),    32'h0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
